kugelblitz_axil_regfile: RTL and testbench
==========================================

KUGELBLITZ_AXIL_REGFILE -- requirements
Module: kugelblitz_axil_regfile

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, 32, AXI-Lite data width (only 32 supported); ADDR_WIDTH, 32, AXI-Lite address width; STRB_WIDTH, DATA_WIDTH/8, write-strobe width; KG_ADDR_WIDTH, 6, byte index within a 512-bit beat; KG_DATA_WIDTH, 8, override byte width.
REQ-002 Ports SHALL be: clk  in  1  sole clock; all logic on rising edge.
REQ-003 rst  in  1  reset, asynchronous and active-low.
REQ-004 s_axil_awaddr in ADDR_WIDTH; s_axil_awprot in 3 (ignored); s_axil_awvalid in 1; s_axil_awready out 1.
REQ-005 s_axil_wdata in DATA_WIDTH; s_axil_wstrb in STRB_WIDTH; s_axil_wvalid in 1; s_axil_wready out 1.
REQ-006 s_axil_bresp out 2; s_axil_bvalid out 1; s_axil_bready in 1.
REQ-007 s_axil_araddr in ADDR_WIDTH; s_axil_arprot in 3 (ignored); s_axil_arvalid in 1; s_axil_arready out 1.
REQ-008 s_axil_rdata out DATA_WIDTH; s_axil_rresp out 2; s_axil_rvalid out 1; s_axil_rready in 1.
REQ-009 kg_address out KG_ADDR_WIDTH (byte lane to override); kg_address_valid out 1; kg_data out KG_DATA_WIDTH (override byte); kg_data_valid out 1.

Function
REQ-010 Register map (decode addr[ADDR_WIDTH-1:2], addr[1:0] ignored): 0x00 CTRL RW bit0 addr_en, bit1 data_en; 0x04 KG_ADDR RW [5:0]; 0x08 KG_DATA RW [7:0]; 0x0C ID RO 0x4B470001 (see REQ-025).
REQ-011 Unimplemented bits SHALL read 0; writes to them ignored.
REQ-012 kg_address=KG_ADDR, kg_data=KG_DATA, kg_address_valid=CTRL[0], kg_data_valid=CTRL[1]; all driven directly from registers, no combinational path from AXI inputs.
REQ-013 Write accept: when awvalid and wvalid both high and bvalid low, awready and wready SHALL pulse high together for exactly one cycle; register update occurs on that edge.
REQ-014 awready/wready SHALL stay low while only one of awvalid/wvalid is high.
REQ-015 Writes SHALL honour wstrb per byte; bytes with strobe 0 keep old value.
REQ-016 bvalid SHALL rise the cycle after accept and hold, with bresp stable, until bready high; no new write accepted while bvalid high.
REQ-017 bresp/rresp SHALL be OKAY (2'b00) for mapped offsets, SLVERR (2'b10) for unmapped; writes to ID or unmapped offsets change nothing.
REQ-018 Read accept: when arvalid high and rvalid low, arready SHALL pulse one cycle; rvalid rises next cycle with rdata/rresp captured at accept and held until rready.
REQ-019 Read and write channels SHALL be independent; a simultaneous read and write of the same register returns the pre-write value.
REQ-020 Back-to-back throughput: one write per 2 cycles when bready held high; same for reads with rready high.

Reset
REQ-021 While rst low: all registers, awready, wready, bvalid, arready, rvalid, kg_* outputs SHALL be 0; bresp, rresp, rdata 0.
REQ-022 Reset asserted mid-transaction SHALL abort it; no response issued after release.
REQ-023 First transaction SHALL be accepted no earlier than the first edge after rst deasserts.

Configuration
REQ-024 Macro KG_ID_REG_EN SHALL control the ID register.
REQ-025 Defined: offset 0x0C reads 0x4B470001 with OKAY, writes SLVERR. Undefined: 0x0C is unmapped (reads 0, SLVERR).

Structure
REQ-026 Shared package kugelblitz_pkg SHALL hold register offsets, ID constant, CTRL bit positions and AXI response codes.
REQ-027 Single flat module; no sub-module is natural.

Verification
REQ-028 After reset, read 0x00/0x04/0x08 -> 0x0, OKAY; kg_* all 0.
REQ-029 Write 0x04=0x0000002A, 0x08=0x000000A5, 0x00=0x3 -> kg_address=42, kg_data=0xA5, both valids 1; bresp OKAY.
REQ-030 Write 0x08=0xFFFFFFFF wstrb=0x0 -> KG_DATA unchanged; wstrb=0x1 -> reads 0xFF.
REQ-031 Awvalid 3 cycles before wvalid, bready low 4 cycles -> single accept, bvalid held, no second accept.
REQ-032 Read 0x0C with KG_ID_REG_EN -> 0x4B470001 OKAY; without -> 0, SLVERR; read 0x40 -> 0, SLVERR.
REQ-033 Assert rst low with bvalid pending -> bvalid and kg_* drop to 0 immediately, no response after release.

Source files
------------

// File: rtl/kugelblitz_pkg.sv
// Shared constants for the Kugelblitz AXI-Lite override register file:
// register offsets, ID value, CTRL bit positions and AXI response codes.
package kugelblitz_pkg;

    localparam logic [31:0] KG_OFF_CTRL = 32'h0000_0000;
    localparam logic [31:0] KG_OFF_ADDR = 32'h0000_0004;
    localparam logic [31:0] KG_OFF_DATA = 32'h0000_0008;
    localparam logic [31:0] KG_OFF_ID   = 32'h0000_000C;

    localparam logic [31:0] KG_ID_VALUE = 32'h4B47_0001;

    localparam int KG_CTRL_ADDR_EN_BIT = 0;
    localparam int KG_CTRL_DATA_EN_BIT = 1;

    typedef enum logic [1:0] {
        AXI_RESP_OKAY   = 2'b00,
        AXI_RESP_EXOKAY = 2'b01,
        AXI_RESP_SLVERR = 2'b10,
        AXI_RESP_DECERR = 2'b11
    } axi_resp_e;

endpackage

// File: rtl/kugelblitz_axil_regfile.sv
// AXI-Lite slave holding the Kugelblitz byte-override controls (CTRL, KG_ADDR, KG_DATA).
// Define KG_ID_REG_EN to expose the read-only ID register at offset 0x0C.
module kugelblitz_axil_regfile
    import kugelblitz_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 32,
    parameter int STRB_WIDTH    = DATA_WIDTH / 8,
    parameter int KG_ADDR_WIDTH = 6,
    parameter int KG_DATA_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,

    input  logic [ADDR_WIDTH-1:0]    s_axil_awaddr,
    input  logic [2:0]               s_axil_awprot,
    input  logic                     s_axil_awvalid,
    output logic                     s_axil_awready,

    input  logic [DATA_WIDTH-1:0]    s_axil_wdata,
    input  logic [STRB_WIDTH-1:0]    s_axil_wstrb,
    input  logic                     s_axil_wvalid,
    output logic                     s_axil_wready,

    output logic [1:0]               s_axil_bresp,
    output logic                     s_axil_bvalid,
    input  logic                     s_axil_bready,

    input  logic [ADDR_WIDTH-1:0]    s_axil_araddr,
    input  logic [2:0]               s_axil_arprot,
    input  logic                     s_axil_arvalid,
    output logic                     s_axil_arready,

    output logic [DATA_WIDTH-1:0]    s_axil_rdata,
    output logic [1:0]               s_axil_rresp,
    output logic                     s_axil_rvalid,
    input  logic                     s_axil_rready,

    output logic [KG_ADDR_WIDTH-1:0] kg_address,
    output logic                     kg_address_valid,
    output logic [KG_DATA_WIDTH-1:0] kg_data,
    output logic                     kg_data_valid
);

    logic                     r_active;
    logic                     r_ctrl_addr_en;
    logic                     r_ctrl_data_en;
    logic [KG_ADDR_WIDTH-1:0] r_kg_addr;
    logic [KG_DATA_WIDTH-1:0] r_kg_data;

    logic                     r_bvalid;
    axi_resp_e                r_bresp;
    logic                     r_rvalid;
    axi_resp_e                r_rresp;
    logic [DATA_WIDTH-1:0]    r_rdata;

    logic                     w_wr_accept;
    logic                     w_rd_accept;
    logic [ADDR_WIDTH-1:0]    w_wr_addr;
    logic [ADDR_WIDTH-1:0]    w_rd_addr;
    logic                     w_wr_sel_ctrl;
    logic                     w_wr_sel_addr;
    logic                     w_wr_sel_data;
    axi_resp_e                w_wr_resp;
    logic [DATA_WIDTH-1:0]    w_rd_data;
    axi_resp_e                w_rd_resp;
    logic                     w_unused;

    // Nothing is accepted until one edge after reset release, so readies stay low during reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_active <= 1'b0;
        end else begin
            r_active <= 1'b1;
        end
    end

    assign w_wr_accept = r_active & s_axil_awvalid & s_axil_wvalid & ~r_bvalid;
    assign w_rd_accept = r_active & s_axil_arvalid & ~r_rvalid;

    assign w_wr_addr = {s_axil_awaddr[ADDR_WIDTH-1:2], 2'b00};
    assign w_rd_addr = {s_axil_araddr[ADDR_WIDTH-1:2], 2'b00};

    always_comb begin
        w_wr_sel_ctrl = (w_wr_addr == ADDR_WIDTH'(KG_OFF_CTRL));
        w_wr_sel_addr = (w_wr_addr == ADDR_WIDTH'(KG_OFF_ADDR));
        w_wr_sel_data = (w_wr_addr == ADDR_WIDTH'(KG_OFF_DATA));
        w_wr_resp     = (w_wr_sel_ctrl | w_wr_sel_addr | w_wr_sel_data) ?
                        AXI_RESP_OKAY : AXI_RESP_SLVERR;
    end

    // All implemented fields live in byte lane 0, so only wstrb[0] gates the update.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ctrl_addr_en <= 1'b0;
            r_ctrl_data_en <= 1'b0;
            r_kg_addr      <= '0;
            r_kg_data      <= '0;
        end else if (w_wr_accept && s_axil_wstrb[0]) begin
            if (w_wr_sel_ctrl) begin
                r_ctrl_addr_en <= s_axil_wdata[KG_CTRL_ADDR_EN_BIT];
                r_ctrl_data_en <= s_axil_wdata[KG_CTRL_DATA_EN_BIT];
            end
            if (w_wr_sel_addr) begin
                r_kg_addr <= s_axil_wdata[KG_ADDR_WIDTH-1:0];
            end
            if (w_wr_sel_data) begin
                r_kg_data <= s_axil_wdata[KG_DATA_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bvalid <= 1'b0;
            r_bresp  <= AXI_RESP_OKAY;
        end else if (w_wr_accept) begin
            r_bvalid <= 1'b1;
            r_bresp  <= w_wr_resp;
        end else if (s_axil_bready) begin
            r_bvalid <= 1'b0;
        end
    end

    always_comb begin
        w_rd_data = '0;
        w_rd_resp = AXI_RESP_SLVERR;
        if (w_rd_addr == ADDR_WIDTH'(KG_OFF_CTRL)) begin
            w_rd_data[KG_CTRL_ADDR_EN_BIT] = r_ctrl_addr_en;
            w_rd_data[KG_CTRL_DATA_EN_BIT] = r_ctrl_data_en;
            w_rd_resp = AXI_RESP_OKAY;
        end else if (w_rd_addr == ADDR_WIDTH'(KG_OFF_ADDR)) begin
            w_rd_data = DATA_WIDTH'(r_kg_addr);
            w_rd_resp = AXI_RESP_OKAY;
        end else if (w_rd_addr == ADDR_WIDTH'(KG_OFF_DATA)) begin
            w_rd_data = DATA_WIDTH'(r_kg_data);
            w_rd_resp = AXI_RESP_OKAY;
        end
`ifdef KG_ID_REG_EN
        else if (w_rd_addr == ADDR_WIDTH'(KG_OFF_ID)) begin
            w_rd_data = DATA_WIDTH'(KG_ID_VALUE);
            w_rd_resp = AXI_RESP_OKAY;
        end
`endif
    end

    // Read data is captured at accept, so a same-cycle write is not visible in it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rvalid <= 1'b0;
            r_rresp  <= AXI_RESP_OKAY;
            r_rdata  <= '0;
        end else if (w_rd_accept) begin
            r_rvalid <= 1'b1;
            r_rresp  <= w_rd_resp;
            r_rdata  <= w_rd_data;
        end else if (s_axil_rready) begin
            r_rvalid <= 1'b0;
        end
    end

    assign s_axil_awready   = w_wr_accept;
    assign s_axil_wready    = w_wr_accept;
    assign s_axil_bvalid    = r_bvalid;
    assign s_axil_bresp     = r_bresp;
    assign s_axil_arready   = w_rd_accept;
    assign s_axil_rvalid    = r_rvalid;
    assign s_axil_rresp     = r_rresp;
    assign s_axil_rdata     = r_rdata;

    assign kg_address       = r_kg_addr;
    assign kg_data          = r_kg_data;
    assign kg_address_valid = r_ctrl_addr_en;
    assign kg_data_valid    = r_ctrl_data_en;

    assign w_unused = ^{s_axil_awprot, s_axil_arprot,
                        s_axil_awaddr[1:0], s_axil_araddr[1:0],
                        s_axil_wstrb[STRB_WIDTH-1:1],
                        s_axil_wdata[DATA_WIDTH-1:KG_DATA_WIDTH]};

endmodule

// File: tb/tb_kugelblitz_axil_regfile.sv
// Directed self-checking bench for kugelblitz_axil_regfile.
// Expects the ID register only when KG_ID_REG_EN is defined.
module tb_kugelblitz_axil_regfile;

    localparam int BOUND = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [5:0]  kgAddress;
    logic        kgAddressValid;
    logic [7:0]  kgData;
    logic        kgDataValid;

    int nAsserts = 0;
    int nFail    = 0;

    always #5 clk = ~clk;

    kugelblitz_axil_regfile dut (
        .clk              (clk),
        .rst              (rst),
        .s_axil_awaddr    (awaddr),
        .s_axil_awprot    (awprot),
        .s_axil_awvalid   (awvalid),
        .s_axil_awready   (awready),
        .s_axil_wdata     (wdata),
        .s_axil_wstrb     (wstrb),
        .s_axil_wvalid    (wvalid),
        .s_axil_wready    (wready),
        .s_axil_bresp     (bresp),
        .s_axil_bvalid    (bvalid),
        .s_axil_bready    (bready),
        .s_axil_araddr    (araddr),
        .s_axil_arprot    (arprot),
        .s_axil_arvalid   (arvalid),
        .s_axil_arready   (arready),
        .s_axil_rdata     (rdata),
        .s_axil_rresp     (rresp),
        .s_axil_rvalid    (rvalid),
        .s_axil_rready    (rready),
        .kg_address       (kgAddress),
        .kg_address_valid (kgAddressValid),
        .kg_data          (kgData),
        .kg_data_valid    (kgDataValid)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nAsserts++;
        assert (observed === expected) else begin
            nFail++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled on the falling edge.
    task automatic axilWrite(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        logic gotAccept;
        logic gotResp;
        gotAccept = 1'b0;
        gotResp   = 1'b0;
        resp      = 2'bxx;
        @(posedge clk); #1;
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1;
        for (int i = 0; i < BOUND; i++) begin
            @(negedge clk);
            if (awready && wready) begin
                gotAccept = 1'b1;
                break;
            end
        end
        checkOutput("wr_accept_seen", {31'd0, gotAccept}, 32'd1);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        for (int i = 0; i < BOUND; i++) begin
            @(negedge clk);
            if (bvalid) begin
                gotResp = 1'b1;
                resp    = bresp;
                break;
            end
        end
        checkOutput("wr_bvalid_seen", {31'd0, gotResp}, 32'd1);
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    task automatic axilRead(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
        logic gotAccept;
        logic gotResp;
        gotAccept = 1'b0;
        gotResp   = 1'b0;
        data      = 32'hxxxx_xxxx;
        resp      = 2'bxx;
        @(posedge clk); #1;
        araddr = addr; arvalid = 1'b1;
        for (int i = 0; i < BOUND; i++) begin
            @(negedge clk);
            if (arready) begin
                gotAccept = 1'b1;
                break;
            end
        end
        checkOutput("rd_accept_seen", {31'd0, gotAccept}, 32'd1);
        @(posedge clk); #1;
        arvalid = 1'b0; rready = 1'b1;
        for (int i = 0; i < BOUND; i++) begin
            @(negedge clk);
            if (rvalid) begin
                gotResp = 1'b1;
                data    = rdata;
                resp    = rresp;
                break;
            end
        end
        checkOutput("rd_rvalid_seen", {31'd0, gotResp}, 32'd1);
        @(posedge clk); #1;
        rready = 1'b0;
    endtask

    task automatic applyStimulus();
        logic [31:0] rd;
        logic [1:0]  rsp;
        int          accepts;
        logic        sawBvalid;

        // Reset with both channels requesting: nothing may be accepted.
        rst = 1'b0;
        awaddr = 32'h0; awprot = 3'b0; wdata = 32'h0; wstrb = 4'h0;
        araddr = 32'h0; arprot = 3'b0; bready = 1'b0; rready = 1'b0;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("rst_awready", {31'd0, awready}, 32'd0);
        checkOutput("rst_wready", {31'd0, wready}, 32'd0);
        checkOutput("rst_arready", {31'd0, arready}, 32'd0);
        checkOutput("rst_bvalid", {31'd0, bvalid}, 32'd0);
        checkOutput("rst_rvalid", {31'd0, rvalid}, 32'd0);
        checkOutput("rst_kg_outputs", {16'd0, kgAddress, kgAddressValid, kgData, kgDataValid}, 32'd0);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        rst = 1'b1;

        // Post-reset reads of the RW registers.
        axilRead(32'h00, rd, rsp);
        checkOutput("rd_ctrl_reset", rd, 32'h0);
        checkOutput("rd_ctrl_reset_resp", {30'd0, rsp}, 32'd0);
        axilRead(32'h04, rd, rsp);
        checkOutput("rd_kgaddr_reset", rd, 32'h0);
        checkOutput("rd_kgaddr_reset_resp", {30'd0, rsp}, 32'd0);
        axilRead(32'h08, rd, rsp);
        checkOutput("rd_kgdata_reset", rd, 32'h0);
        checkOutput("rd_kgdata_reset_resp", {30'd0, rsp}, 32'd0);

        // Program the override; upper CTRL bits must be discarded.
        axilWrite(32'h04, 32'h0000_002A, 4'hF, rsp);
        checkOutput("wr_kgaddr_resp", {30'd0, rsp}, 32'd0);
        axilWrite(32'h08, 32'h0000_00A5, 4'hF, rsp);
        checkOutput("wr_kgdata_resp", {30'd0, rsp}, 32'd0);
        axilWrite(32'h00, 32'hFFFF_FFFF, 4'hF, rsp);
        checkOutput("wr_ctrl_resp", {30'd0, rsp}, 32'd0);
        checkOutput("kg_address", {26'd0, kgAddress}, 32'd42);
        checkOutput("kg_data", {24'd0, kgData}, 32'hA5);
        checkOutput("kg_valids", {30'd0, kgDataValid, kgAddressValid}, 32'h3);
        axilRead(32'h00, rd, rsp);
        checkOutput("rd_ctrl_masked", rd, 32'h3);
        axilRead(32'h05, rd, rsp);
        checkOutput("rd_kgaddr_lowbits_ignored", rd, 32'h2A);

        // Byte strobes.
        axilWrite(32'h08, 32'hFFFF_FFFF, 4'h0, rsp);
        checkOutput("wr_strb0_resp", {30'd0, rsp}, 32'd0);
        axilRead(32'h08, rd, rsp);
        checkOutput("rd_strb0_unchanged", rd, 32'hA5);
        axilWrite(32'h08, 32'hFFFF_FFFF, 4'h1, rsp);
        axilRead(32'h08, rd, rsp);
        checkOutput("rd_strb1_written", rd, 32'hFF);

        // AW leads W by 3 cycles; bready held low while the master keeps requesting.
        @(posedge clk); #1;
        awaddr = 32'h08; wdata = 32'h11; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b0;
        accepts = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (awready || wready) accepts++;
            @(posedge clk); #1;
        end
        checkOutput("aw_only_no_accept", accepts, 0);
        wvalid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (awready && wready) accepts++;
            @(posedge clk); #1;
        end
        checkOutput("single_accept", accepts, 1);
        checkOutput("bvalid_held", {31'd0, bvalid}, 32'd1);
        checkOutput("bresp_held", {30'd0, bresp}, 32'd0);
        checkOutput("kg_data_after_held", {24'd0, kgData}, 32'h11);
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        @(negedge clk);
        checkOutput("bvalid_cleared", {31'd0, bvalid}, 32'd0);

        // ID and unmapped offsets.
        axilRead(32'h0C, rd, rsp);
`ifdef KG_ID_REG_EN
        checkOutput("rd_id", rd, 32'h4B47_0001);
        checkOutput("rd_id_resp", {30'd0, rsp}, 32'd0);
`else
        checkOutput("rd_id_absent", rd, 32'h0);
        checkOutput("rd_id_absent_resp", {30'd0, rsp}, 32'd2);
`endif
        axilRead(32'h40, rd, rsp);
        checkOutput("rd_unmapped", rd, 32'h0);
        checkOutput("rd_unmapped_resp", {30'd0, rsp}, 32'd2);
        axilWrite(32'h40, 32'h0000_0000, 4'hF, rsp);
        checkOutput("wr_unmapped_resp", {30'd0, rsp}, 32'd2);
        axilWrite(32'h0C, 32'h0000_0000, 4'hF, rsp);
        checkOutput("wr_id_resp", {30'd0, rsp}, 32'd2);
        checkOutput("kg_after_bad_writes", {16'd0, kgAddress, kgAddressValid, kgData, kgDataValid},
                    {16'd0, 6'd42, 1'b1, 8'h11, 1'b1});

        // Simultaneous read and write of KG_DATA returns the old value.
        @(posedge clk); #1;
        awaddr = 32'h08; wdata = 32'h77; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 32'h08; arvalid = 1'b1;
        @(negedge clk);
        checkOutput("simul_readies", {29'd0, awready, wready, arready}, 32'h7);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b1; rready = 1'b1;
        @(negedge clk);
        checkOutput("simul_valids", {30'd0, bvalid, rvalid}, 32'h3);
        checkOutput("simul_rdata_old", rdata, 32'h11);
        checkOutput("simul_kg_data_new", {24'd0, kgData}, 32'h77);
        @(posedge clk); #1;
        bready = 1'b0; rready = 1'b0;

        // Back-to-back writes with bready high: one accept every two cycles.
        awaddr = 32'h04; wdata = 32'h15; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        accepts = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (awready && wready) accepts++;
        end
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
        checkOutput("b2b_write_accepts", accepts, 3);
        checkOutput("b2b_kg_address", {26'd0, kgAddress}, 32'h15);

        // Reset while a write response is pending.
        awaddr = 32'h08; wdata = 32'h33; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk);
        checkOutput("pending_accept", {30'd0, awready, wready}, 32'h3);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        checkOutput("pending_bvalid", {31'd0, bvalid}, 32'd1);
        checkOutput("pending_kg_data", {24'd0, kgData}, 32'h33);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("midrst_bvalid", {31'd0, bvalid}, 32'd0);
        checkOutput("midrst_kg_outputs", {16'd0, kgAddress, kgAddressValid, kgData, kgDataValid}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1; bready = 1'b1;
        sawBvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bvalid) sawBvalid = 1'b1;
        end
        checkOutput("no_resp_after_release", {31'd0, sawBvalid}, 32'd0);
        @(posedge clk); #1;
        bready = 1'b0;
        axilRead(32'h00, rd, rsp);
        checkOutput("rd_ctrl_after_midrst", rd, 32'h0);
    endtask

    initial begin
        applyStimulus();
        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
